// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq
// ------------------------------------------------------------------------
// Sequences a WIDTH-bit add through a shared 4-bit carry-lookahead adder.
// The adder is used once per clock, least-significant nibble first. The
// carry is chained from one nibble to the next. When the last nibble is
// done, the block reports the full sum, the final carry-out and the
// two's-complement overflow flag.
//
// Optional feature macro: ADDSEQ_SUB_EN
//   defined   : req_sub_i=1 computes A-B as A + ~B + 1 (req_cin_i ignored),
//               and rsp_cout_o=1 then means "no borrow".
//   undefined : req_sub_i is ignored and no inversion logic is built.
//
// Ports
//   clk_i        rising-edge clock
//   res_ni       asynchronous active-low reset
//   req_valid_i  request present            req_ready_o  request accepted in IDLE
//   req_a_i      operand A                  req_b_i      operand B
//   req_cin_i    carry-in for an add        req_sub_i    1 = A-B (macro only)
//   rsp_valid_o  result available           rsp_ready_i  consumer takes result
//   rsp_sum_o    WIDTH-bit result           rsp_cout_o   final carry-out
//   rsp_ovf_o    signed overflow            busy_o       high in RUN or DONE
//   adder_x_o    A nibble to the adder      adder_y_o    effective-B nibble
//   adder_cin_o  chained carry to adder     adder_z_i    adder sum
//   adder_cout_i adder carry-out
// ------------------------------------------------------------------------
module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             res_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic             req_cin_i,
    input  logic             req_sub_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_sum_o,
    output logic             rsp_cout_o,
    output logic             rsp_ovf_o,
    output logic             busy_o,
    output logic [3:0]       adder_x_o,
    output logic [3:0]       adder_y_o,
    output logic             adder_cin_o,
    input  logic [3:0]       adder_z_i,
    input  logic             adder_cout_i
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    // A width that is not a whole number of nibbles cannot be sequenced.
    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("cla_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The effective B operand and the starting carry are fixed when the
    // request is accepted. A subtract is an add of ~B with a carry-in of 1.
`ifdef ADDSEQ_SUB_EN
    assign b_eff   = req_sub_i ? ~req_b_i : req_b_i;
    assign cin_eff = req_sub_i ? 1'b1 : req_cin_i;
`else
    assign b_eff   = req_b_i;
    assign cin_eff = req_cin_i;

    logic unused_sub;
    assign unused_sub = req_sub_i;
`endif

    // Next nibble index. Overflow is judged on the MSB nibble, using the
    // adder's live sum bit before it is stored.
    always_comb begin
        idx_d = idx_q + IDX_W'(1);
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (adder_z_i[3] != a_q[WIDTH-1]);
    end

    // This block owns the adder inputs. They are non-zero only while RUN
    // is stepping through the nibbles; in every other state they are held
    // at zero.
    always_comb begin
        adder_x_o   = '0;
        adder_y_o   = '0;
        adder_cin_o = 1'b0;
        if (state_q == RUN) begin
            adder_cin_o = carry_q;
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == IDX_W'(n)) begin
                    adder_x_o = a_q[4*n +: 4];
                    adder_y_o = b_q[4*n +: 4];
                end
            end
        end
    end

    // Main FSM. IDLE accepts a request and latches the operands, so later
    // changes on the request inputs have no effect. RUN stores one adder
    // result per clock and passes the carry forward. DONE holds the
    // response until the consumer takes it. A reset at any point discards
    // the partial result.
    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        a_q     <= req_a_i;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (idx_q == IDX_W'(n)) begin
                            sum_q[4*n +: 4] <= adder_z_i;
                        end
                    end
                    carry_q <= adder_cout_i;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= adder_cout_i;
                        ovf_q   <= ovf_d;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs are taken straight from the state
    // register. req_ready stays low while reset is asserted.
    assign req_ready_o = (state_q == IDLE) && res_ni;
    assign rsp_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_sum_o   = sum_q;
    assign rsp_cout_o  = cout_q;
    assign rsp_ovf_o   = ovf_q;

endmodule

// File: doc/cla_nibble_seq.md
Name: cla_nibble_seq

Overview:
- Sequencer that performs WIDTH-bit additions (and optional subtractions) on the shared 4-bit carry-lookahead adder (x, y, cin -> z, cout), one nibble per clock, LSB nibble first.
- Sits between a valid/ready requester and the adder instance, and owns the adder inputs exclusively.
- Chains the carry between nibbles, assembles the full result, and reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; other values are illegal (elaboration error).
- NIBBLES, WIDTH/4, derived count of adder passes. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- res  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_cin  in  1  carry-in for the add operation
- req_sub  in  1  1 = A-B (only when ADDSEQ_SUB_EN is defined)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_sum  out  WIDTH  result
- rsp_cout  out  1  final carry-out (for subtract: 1 = no borrow)
- rsp_ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN or DONE
- adder_x  out  4  slice of A to the adder
- adder_y  out  4  slice of effective B to the adder
- adder_cin  out  1  chained carry to the adder
- adder_z  in  4  adder sum (combinational)
- adder_cout  in  1  adder carry-out (combinational)

Behaviour:
- Reset (res=0, asynchronous):
  - State IDLE; index=0; all registers cleared.
  - req_ready=1 once res deasserts.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0.
  - adder_x, adder_y, adder_cin = 0.
- FSM states:
  - IDLE: req_ready=1. On an edge with req_valid=1:
    - latch A, Beff (= B, or ~B when subtracting) and carry (= req_cin, or 1 when subtracting);
    - clear index; go to RUN.
  - RUN: req_ready=0.
    - Combinational drive: adder_x=A[4i+3:4i], adder_y=Beff[4i+3:4i], adder_cin=carry.
    - On each edge: sum[4i+3:4i] <= adder_z; carry <= adder_cout; i <= i+1.
    - On the edge where i==NIBBLES-1: capture rsp_cout and rsp_ovf; go to DONE.
  - DONE: rsp_valid=1; rsp_* held stable. On an edge with rsp_ready=1, go to IDLE.
- Adder inputs are driven to 0 in every state except RUN.
- Latency:
  - Request accepted on edge E. rsp_valid rises after edge E+NIBBLES (E+4 for WIDTH=16).
  - Minimum request spacing is NIBBLES+2 cycles. There is no accept in DONE.
- Overflow: rsp_ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
- Boundary conditions:
  - rsp_ready held low: DONE persists indefinitely with outputs stable.
  - req_valid ignored outside IDLE.
  - req inputs may change after acceptance without effect.
  - Reset mid-RUN or in DONE aborts the operation and returns to IDLE with reset values. The partial result is discarded.
  - WIDTH=4: single RUN cycle.
  - Carry wraps out of the MSB into rsp_cout only; the sum wraps modulo 2^WIDTH.

Optional Feature:
- Macro ADDSEQ_SUB_EN.
- Defined: req_sub=1 sets Beff=~req_b and the initial carry to 1, ignoring req_cin. rsp_cout=1 means no borrow.
- Undefined: req_sub is ignored, Beff=req_b always, and no inversion logic is built.

Test Plan:
- Basic add: A=0x1234, B=0x4321, cin=0 -> rsp_sum=0x5555, cout=0, ovf=0; rsp_valid exactly 4 edges after accept; adder_x sequence 4,3,2,1.
- Carry ripple: A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also A=0x0000, B=0x0000, cin=1 -> sum=0x0001.
- Signed overflow: A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1. A=0x8000, B=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure and handshake:
  - hold rsp_ready=0 for 10 cycles with req_valid=1 throughout -> rsp_* stable, req_ready=0;
  - release -> IDLE next edge, second request accepted the following edge.
- Reset mid-operation: pull res low during RUN nibble 2 -> all outputs zero immediately (asynchronously); after release, A=0x0001, B=0x0002 -> sum=0x0003.
- With ADDSEQ_SUB_EN:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - Without the macro, req_sub=1 with 0x0005, 0x0007 -> sum=0x000C.
